// File: rtl/bcd_display_ctrl_pkg.sv
// Shared constants for the BCD display controller: FSM encoding, digit geometry, glyphs.
// Pure declarations; no latency or backpressure of its own.
package bcd_display_ctrl_pkg;

    localparam int NUM_DIGITS = 5;
    localparam int DIG_IDX_W  = 3;
    localparam int BCD_W      = NUM_DIGITS * 4;

    typedef logic [3:0]            bcd_digit_t;
    typedef logic [BCD_W-1:0]      bcd_word_t;
    typedef logic [DIG_IDX_W-1:0]  dig_idx_t;
    typedef logic [NUM_DIGITS-1:0] an_t;

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam an_t AN_OFF = '1;

    function automatic an_t digit_enable(input dig_idx_t idx);
        return ~(an_t'(1) << idx);
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_seg7_decode.sv
// BCD nibble to active-low seven-segment glyph; non-decimal nibbles show '-'.
// Purely combinational, zero latency, no flow control.
module seg7_decode
    import bcd_display_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Periodic level handshake with a binary-to-BCD converter feeding a 5-digit multiplexed display.
// Result latched 1 cycle after bcd_done; each handshake edge is bounded by TIMEOUT, after which err sticks.
module bcd_display_ctrl
    import bcd_display_ctrl_pkg::*;
#(
    parameter int UPDATE_DIV  = 10_000_000,
    parameter int REFRESH_DIV = 100_000,
    parameter int TIMEOUT     = 1_000,
    parameter int BLANK_LZ    = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    output logic                  conv_start,
    input  logic                  bcd_done,
    input  logic [BCD_W-1:0]      bcd_in,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  err
);

    localparam int UPD_W = $clog2(UPDATE_DIV + 1);
    localparam int REF_W = $clog2(REFRESH_DIV + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_DIV - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [UPD_W-1:0] wait_cnt;
    logic [TO_W-1:0]  to_cnt;
    bcd_word_t        disp;

    logic [REF_W-1:0]      ref_cnt;
    dig_idx_t              idx;
    logic [NUM_DIGITS-1:0] blank;
    logic                  hi_zero;
    bcd_digit_t            sel_nib;
    logic                  sel_blank;
    logic [6:0]            dec_seg;

    // Handshake FSM: conv_start is registered alongside the state so it tracks REQ exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_WAIT;
            wait_cnt   <= '0;
            to_cnt     <= '0;
            conv_start <= 1'b0;
            err        <= 1'b0;
            disp       <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == UPD_LAST) begin
                        state      <= ST_REQ;
                        conv_start <= 1'b1;
                        wait_cnt   <= '0;
                        to_cnt     <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bcd_done) begin
                        disp       <= bcd_in;
                        state      <= ST_REL;
                        conv_start <= 1'b0;
                        to_cnt     <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        err        <= 1'b1;
                        state      <= ST_WAIT;
                        conv_start <= 1'b0;
                        wait_cnt   <= '0;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_REL: begin
                    if (!bcd_done) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                        to_cnt   <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        err      <= 1'b1;
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= ST_WAIT;
                    conv_start <= 1'b0;
                    wait_cnt   <= '0;
                    to_cnt     <= '0;
                end
            endcase
        end
    end

    // A digit is blanked when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        blank   = '0;
        hi_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            hi_zero  = hi_zero && (disp[4*i +: 4] == 4'd0);
            blank[i] = hi_zero && (BLANK_LZ != 0);
        end
    end

    always_comb begin
        sel_nib   = disp[3:0];
        sel_blank = blank[0];
        case (idx)
            3'd0: begin sel_nib = disp[3:0];   sel_blank = blank[0]; end
            3'd1: begin sel_nib = disp[7:4];   sel_blank = blank[1]; end
            3'd2: begin sel_nib = disp[11:8];  sel_blank = blank[2]; end
            3'd3: begin sel_nib = disp[15:12]; sel_blank = blank[3]; end
            3'd4: begin sel_nib = disp[19:16]; sel_blank = blank[4]; end
            default: begin sel_nib = disp[3:0]; sel_blank = blank[0]; end
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd (sel_nib),
        .seg (dec_seg)
    );

    // Outputs load only at the start of a slot, so a new display value waits for the next slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            an      <= AN_OFF;
            seg     <= SEG_OFF;
        end else begin
            if (ref_cnt == '0) begin
                an  <= sel_blank ? AN_OFF : digit_enable(idx);
                seg <= dec_seg;
            end
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                idx     <= (idx == dig_idx_t'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed-plus-random bench: converter model with random latency, scan observer, reference digits by arithmetic.
// Checks handshake timing, timeout/err, blanking, glyphs and asynchronous reset.
module tb_bcd_display_ctrl;

    logic        clk;
    logic        rst;
    logic        conv_start;
    logic        bcd_done;
    logic [19:0] bcd_in;
    logic [4:0]  an;
    logic [6:0]  seg;
    logic        err;

    bcd_display_ctrl #(
        .UPDATE_DIV  (20),
        .REFRESH_DIV (4),
        .TIMEOUT     (50),
        .BLANK_LZ    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .conv_start (conv_start),
        .bcd_done   (bcd_done),
        .bcd_in     (bcd_in),
        .an         (an),
        .seg        (seg),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [6:0] dash_glyph = 7'b0111111;
    int pow10 [5] = '{1, 10, 100, 1000, 10000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Converter model: level start / level done, done held until start drops.
    int          conv_val   = 0;
    bit          conv_stuck = 1'b0;
    bit          raw_en     = 1'b0;
    logic [19:0] raw_val    = '0;
    int          lat        = -1;

    initial begin
        bcd_done = 1'b0;
        bcd_in   = '0;
        forever begin
            @(negedge clk);
            if (rst || !conv_start) begin
                bcd_done = 1'b0;
                lat      = -1;
            end else if (!bcd_done) begin
                if (lat < 0) begin
                    lat = int'($urandom_range(12, 18));
                end else if (lat == 0) begin
                    if (!conv_stuck) begin
                        bcd_in   = raw_en ? raw_val : to_bcd(conv_val);
                        bcd_done = 1'b1;
                    end
                end else begin
                    lat--;
                end
            end
        end
    end

    task automatic wait_level(input logic lvl, input int limit, output int cyc);
        cyc = 0;
        while (conv_start !== lvl && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic handshake();
        int c;
        wait_level(1'b0, 200, c);
        wait_level(1'b1, 200, c);
        wait_level(1'b0, 200, c);
    endtask

    // Scan observer results
    logic [4:0] obs_mask;
    logic [6:0] obs_seg [5];
    int         obs_bad;
    int         obs_rmin;
    int         obs_rmax;

    task automatic observe(input int ncyc);
        logic [4:0] prev;
        int run;
        int nruns;
        obs_mask = '0;
        obs_bad  = 0;
        obs_rmin = 1000;
        obs_rmax = 0;
        run      = 0;
        nruns    = 0;
        prev     = '1;
        for (int i = 0; i < 5; i++) obs_seg[i] = 7'h7f;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) begin
                prev = an;
                run  = 1;
            end else if (an == prev) begin
                run++;
            end else begin
                if (nruns > 0 && prev != 5'h1f) begin
                    if (run < obs_rmin) obs_rmin = run;
                    if (run > obs_rmax) obs_rmax = run;
                end
                nruns++;
                prev = an;
                run  = 1;
            end
            for (int i = 0; i < 5; i++) begin
                if (an == ~(5'b00001 << i)) begin
                    obs_mask[i] = 1'b1;
                    obs_seg[i]  = seg;
                end
            end
            if (an != 5'h1f && !$onehot(~an)) obs_bad++;
        end
    endtask

    task automatic show_value(input string tag, input int v);
        logic [4:0] exp_mask;
        exp_mask = '0;
        for (int i = 0; i < 5; i++) exp_mask[i] = (i == 0) || (v >= pow10[i]);
        repeat (24) @(negedge clk);
        observe(44);
        check({tag, "_disp"}, 32'(dut.disp), 32'(to_bcd(v)));
        check({tag, "_mask"}, 32'(obs_mask), 32'(exp_mask));
        check({tag, "_multi_low"}, 32'(obs_bad), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (exp_mask[i])
                check($sformatf("%s_seg%0d", tag, i), 32'(obs_seg[i]), 32'(glyph_tab[(v / pow10[i]) % 10]));
        end
    endtask

    initial begin
        int cyc;
        int v;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_conv_start", 32'(conv_start), 32'd0);
        check("rst_an", 32'(an), 32'h1f);
        check("rst_seg", 32'(seg), 32'h7f);
        check("rst_err", 32'(err), 32'd0);
        check("rst_disp", 32'(dut.disp), 32'd0);

        conv_val = 1234;
        rst = 1'b0;
        wait_level(1'b1, 200, cyc);
        check("first_req_delay", 32'(cyc), 32'd20);
        wait_level(1'b0, 200, cyc);
        repeat (3) @(negedge clk);
        check("disp_after_hs", 32'(dut.disp), 32'h01234);
        check("err_after_hs", 32'(err), 32'd0);
        show_value("v1234", 1234);

        // Converter never answers: request must time out
        conv_stuck = 1'b1;
        wait_level(1'b0, 200, cyc);
        wait_level(1'b1, 200, cyc);
        wait_level(1'b0, 200, cyc);
        check("timeout_len", 32'(cyc), 32'd50);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_disp_kept", 32'(dut.disp), 32'h01234);
        conv_stuck = 1'b0;
        conv_val   = 0;
        wait_level(1'b1, 200, cyc);
        check("req_after_timeout", 32'(cyc), 32'd20);
        wait_level(1'b0, 200, cyc);
        show_value("v0", 0);
        check("err_sticky_0", 32'(err), 32'd1);

        conv_val = 65535;
        handshake();
        show_value("v65535", 65535);
        check("slot_len_min", 32'(obs_rmin), 32'd4);
        check("slot_len_max", 32'(obs_rmax), 32'd4);

        repeat (3) begin
            v = int'($urandom_range(0, 65535));
            conv_val = v;
            handshake();
            show_value($sformatf("rnd%0d", v), v);
        end

        // Non-decimal top nibble: shown as '-' and keeps lower zeros lit
        raw_en  = 1'b1;
        raw_val = 20'hA0000;
        handshake();
        repeat (24) @(negedge clk);
        observe(44);
        check("raw_disp", 32'(dut.disp), 32'hA0000);
        check("raw_mask", 32'(obs_mask), 32'h1f);
        check("raw_seg4_dash", 32'(obs_seg[4]), 32'(dash_glyph));
        for (int i = 0; i < 4; i++)
            check($sformatf("raw_seg%0d", i), 32'(obs_seg[i]), 32'(glyph_tab[0]));
        check("err_sticky_1", 32'(err), 32'd1);

        // Asynchronous reset while requesting
        wait_level(1'b0, 200, cyc);
        wait_level(1'b1, 200, cyc);
        check("midreq_conv_high", 32'(conv_start), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midreq_conv_start", 32'(conv_start), 32'd0);
        check("midreq_an", 32'(an), 32'h1f);
        check("midreq_seg", 32'(seg), 32'h7f);
        check("midreq_err", 32'(err), 32'd0);
        check("midreq_disp", 32'(dut.disp), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 SHALL have parameter UPDATE_DIV, default 10_000_000, giving clock cycles between conversion requests (100 ms at 100 MHz).
REQ-002 SHALL have parameter REFRESH_DIV, default 100_000, giving clock cycles each digit is driven.
REQ-003 SHALL have parameter TIMEOUT, default 1_000, giving the maximum cycles to wait for each converter handshake edge.
REQ-004 SHALL have parameter BLANK_LZ, default 1, enabling leading-zero blanking when 1.
REQ-005 clk  in  1  single system clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 conv_start  out  1  level request to the binary-to-BCD converter.
REQ-008 bcd_done  in  1  converter done level, high while its result is held.
REQ-009 bcd_in  in  20  five BCD digits; [3:0] ones through [19:16] ten-thousands.
REQ-010 an  out  5  digit enables, active low; an[0] is the ones digit.
REQ-011 seg  out  7  segments, active low, ordered {g,f,e,d,c,b,a}.
REQ-012 err  out  1  sticky handshake-timeout flag.

Function
REQ-013 The handshake FSM SHALL have states WAIT, REQ and REL.
- WAIT: count UPDATE_DIV cycles, then go to REQ.
- REQ: conv_start=1.
- REL: conv_start=0.
REQ-014 In REQ, on the first cycle bcd_done==1, the block SHALL latch bcd_in into the display register and go to REL.
REQ-015 In REL, the block SHALL return to WAIT on the first cycle bcd_done==0 and restart the UPDATE_DIV count.
REQ-016 If REQ or REL lasts TIMEOUT cycles without its exit condition, the block SHALL:
- set err=1;
- leave the display register unchanged;
- go to WAIT (from REQ this passes through REL semantics, so conv_start drops).
REQ-017 err SHALL clear only on rst.
REQ-018 conv_start SHALL be a registered output, high exactly while the FSM is in REQ.
REQ-019 bcd_done already high on entry to REQ SHALL be accepted as done on that entry cycle; latch latency SHALL be 1 cycle after bcd_done is sampled high.
REQ-020 A scan counter SHALL advance the digit index 0,1,2,3,4,0,... every REFRESH_DIV cycles, wrapping from 4 to 0.
REQ-021 an[i] SHALL be 0 only when index==i and digit i is not blanked; otherwise an SHALL be all ones.
REQ-022 With BLANK_LZ=1, digit i (i>=1) SHALL be blanked when it and all higher digits are zero; digit 0 is never blanked.
REQ-023 seg SHALL encode the decimal glyphs 0-9; any nibble >9 SHALL display '-' (only g lit, i.e. seg=7'b0111111).
REQ-024 seg and an SHALL be registered and change on the same clock edge.
REQ-025 A display register update SHALL take effect at the next digit slot without resetting the scan index.

Reset
REQ-026 On rst, the block SHALL force, asynchronously:
- FSM to WAIT with counters at 0;
- conv_start=0, err=0;
- display register=0;
- an=5'b11111, seg=7'b1111111;
- scan index=0.
REQ-027 On rst release, the first request SHALL occur UPDATE_DIV cycles later.
REQ-028 Reset asserted mid-REQ SHALL drop conv_start in the same cycle, asynchronously.

Structure
REQ-029 The FSM state encoding, the seven-segment glyph constants (0-9 and '-') and the digit count of 5 SHALL live in the shared project package.
REQ-030 The BCD-to-segment decode SHALL be one combinational sub-module named seg7_decode, instantiated once on the selected nibble.

Verification
REQ-031 Use UPDATE_DIV=20, REFRESH_DIV=4 and TIMEOUT=50, with the bench connected to a model of the converter (start-level / done-level, roughly 15-cycle latency) fed 16'd1234.
- conv_start rises 20 cycles after rst release.
- After the handshake the display register holds 20'h01234.
- Digits 3-0 show 1,2,3,4; an[4] stays high.
REQ-032 Converter model fed 16'd0: only an[0] ever goes low, and seg=7'b1000000.
REQ-033 Converter model fed 16'd65535: all five digits scan 6,5,5,3,5, with each an slot lasting 4 cycles.
REQ-034 bcd_done held 0 in the model:
- conv_start falls after 50 cycles;
- err=1;
- the previous value is still displayed;
- the next request occurs 20 cycles later.
REQ-035 bcd_in forced to 20'hA0000: digit 4 shows '-' and is not blanked.
REQ-036 Assert rst while in REQ: conv_start, an and seg reach their reset values with no clock edge, and err=0.
